// File: rtl/cmp_pkg.sv
// Shared encodings for serial_comparer: funct3 values for compare and min/max
// operations, plus the controller state type.
package cmp_pkg;

  localparam logic [2:0] F3_EQ   = 3'b000;
  localparam logic [2:0] F3_NE   = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_LT   = 3'b100;
  localparam logic [2:0] F3_GE   = 3'b101;
  localparam logic [2:0] F3_LTU  = 3'b110;
  localparam logic [2:0] F3_GEU  = 3'b111;

  localparam logic [2:0] F3_MIN  = 3'b100;
  localparam logic [2:0] F3_MINU = 3'b101;
  localparam logic [2:0] F3_MAX  = 3'b110;
  localparam logic [2:0] F3_MAXU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when the operation compares its operands as two's-complement values.
  function automatic logic is_signed_op(input logic [2:0] op, input logic minmax);
    if (minmax) return (op == F3_MIN) || (op == F3_MAX);
    return (op == F3_LT) || (op == F3_GE) || (op == F3_SLT);
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned comparison of one operand slice.
module cmp_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             eq
);

  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/serial_comparer.sv
// Multi-cycle operand comparer: one CHUNK-bit slice per cycle, MSB slice first,
// producing a branch/slt flag or a Zbb min/max result behind valid/ready.
module serial_comparer
  import cmp_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CHUNK      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            minmax,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_flag,
  output logic [XLEN-1:0] out_value
);

  localparam int unsigned NCHUNK = XLEN / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (XLEN % CHUNK != 0) begin : g_bad_chunk
    $fatal(1, "serial_comparer: XLEN must be a multiple of CHUNK");
  end

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic              minmax_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [IDX_W-1:0]  idx_q;
  logic              found_q, lt_q;
  logic              flag_q;
  logic [XLEN-1:0]   value_q;

  logic [XLEN-1:0]   sign_mask, a_cmp, b_cmp;
  logic [CHUNK-1:0]  a_slice, b_slice;
  logic              s_lt, s_eq, decide;
  logic              res_lt, res_eq, flag_d;
  logic [XLEN-1:0]   value_d;

  // Flipping the sign bit turns a signed compare into an unsigned one.
  assign sign_mask = {is_signed_op(op_q, minmax_q), {(XLEN-1){1'b0}}};
  assign a_cmp     = a_q ^ sign_mask;
  assign b_cmp     = b_q ^ sign_mask;
  assign a_slice   = a_cmp[idx_q*CHUNK +: CHUNK];
  assign b_slice   = b_cmp[idx_q*CHUNK +: CHUNK];

  cmp_slice #(.WIDTH(CHUNK)) u_slice (
    .a  (a_slice),
    .b  (b_slice),
    .lt (s_lt),
    .eq (s_eq)
  );

  assign decide = (EARLY_EXIT && !s_eq) || (idx_q == '0);
  // Without early exit, the first differing slice seen decides the ordering.
  assign res_lt = found_q ? lt_q : s_lt;
  assign res_eq = !found_q && s_eq;

  always_comb begin
    flag_d  = 1'b0;
    value_d = '0;
    if (minmax_q) begin
      case (op_q)
        F3_MIN, F3_MINU: begin
          flag_d  = res_lt;
          value_d = res_lt ? a_q : b_q;
        end
        F3_MAX, F3_MAXU: begin
          flag_d  = res_lt;
          value_d = res_lt ? b_q : a_q;
        end
        default: ;
      endcase
    end else begin
      case (op_q)
        F3_EQ:                         flag_d = res_eq;
        F3_NE:                         flag_d = !res_eq;
        F3_LT, F3_SLT, F3_LTU, F3_SLTU: flag_d = res_lt;
        default:                       flag_d = !res_lt;
      endcase
      value_d = XLEN'(flag_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (decide)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Operand capture, slice walk and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      minmax_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      found_q  <= 1'b0;
      lt_q     <= 1'b0;
      flag_q   <= 1'b0;
      value_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            minmax_q <= minmax;
            a_q      <= in1;
            b_q      <= in2;
            idx_q    <= IDX_W'(NCHUNK - 1);
            found_q  <= 1'b0;
            lt_q     <= 1'b0;
          end
        end
        BUSY: begin
          if (decide) begin
            flag_q  <= flag_d;
            value_q <= value_d;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
            if (!found_q && !s_eq) begin
              found_q <= 1'b1;
              lt_q    <= s_lt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_flag  = flag_q;
  assign out_value = value_q;

endmodule

// File: tb/tb_serial_comparer.sv
// Self-checking bench for serial_comparer: scoreboard of expected flag, value
// and latency, with an early-exit instance and a full-scan instance.
module tb_serial_comparer;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CHUNK  = 8;
  localparam int unsigned NCHUNK = XLEN / CHUNK;
  localparam int          TMO    = 16;

  typedef struct {
    logic [2:0]  op;
    logic        mm;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  typedef struct {
    logic        flag;
    logic [31:0] value;
    int          k;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_valid_fs;
  logic [2:0]      op;
  logic            minmax;
  logic [XLEN-1:0] in1, in2;
  logic            out_ready;
  logic            in_ready, out_valid, out_flag;
  logic [XLEN-1:0] out_value;
  logic            fs_in_ready, fs_out_valid, fs_out_flag;
  logic [XLEN-1:0] fs_out_value;

  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_comparer #(.XLEN(XLEN), .CHUNK(CHUNK), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .minmax(minmax), .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_flag(out_flag), .out_value(out_value)
  );

  serial_comparer #(.XLEN(XLEN), .CHUNK(CHUNK), .EARLY_EXIT(1'b0)) dut_fs (
    .clk(clk), .reset(reset), .in_valid(in_valid_fs), .in_ready(fs_in_ready),
    .op(op), .minmax(minmax), .in1(in1), .in2(in2),
    .out_valid(fs_out_valid), .out_ready(out_ready),
    .out_flag(fs_out_flag), .out_value(fs_out_value)
  );

  // Reference behaviour written directly from the operation table.
  function automatic exp_t model(input logic [2:0] o, input logic m,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit ee);
    exp_t e;
    logic sgn, ltv;
    sgn = m ? (o == 3'b100 || o == 3'b110) : (o == 3'b100 || o == 3'b010 || o == 3'b101);
    ltv = sgn ? ($signed(a) < $signed(b)) : (a < b);
    e.flag  = 1'b0;
    e.value = '0;
    if (!m) begin
      case (o)
        3'b000:  e.flag = (a == b);
        3'b001:  e.flag = (a != b);
        3'b101,
        3'b111:  e.flag = !ltv;
        default: e.flag = ltv;
      endcase
      e.value = {31'b0, e.flag};
    end else if (o[2]) begin
      e.flag  = ltv;
      e.value = o[1] ? (ltv ? b : a) : (ltv ? a : b);
    end
    e.k = NCHUNK;
    if (ee) begin
      for (int i = NCHUNK - 1; i >= 0; i--) begin
        if (a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK]) begin
          e.k = NCHUNK - i;
          break;
        end
      end
    end
    return e;
  endfunction

  // Issue one request to the early-exit instance; call at a negedge while idle.
  task automatic send(input logic [2:0] o, input logic m, input logic [31:0] a, input logic [31:0] b);
    op = o; minmax = m; in1 = a; in2 = b;
    in_valid = 1'b1;
    sb.push_back(model(o, m, a, b, 1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen, bounded.
  task automatic wait_out(output int lat, output bit to);
    lat = 0;
    to  = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL reset.in_ready got %b want 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset.out_valid got %b want 0", out_valid); else passed++;
    checks++; if (out_flag !== 1'b0) $display("FAIL reset.out_flag got %b want 0", out_flag); else passed++;
    checks++; if (out_value !== 32'h0) $display("FAIL reset.out_value got %h want 0", out_value); else passed++;
  endtask

  task automatic test_compare();
    req_t tbl [12] = '{
      '{3'b100, 1'b0, 32'h8000_0000, 32'h0000_0000},
      '{3'b000, 1'b0, 32'h1234_5678, 32'h1234_5678},
      '{3'b001, 1'b0, 32'h1234_5678, 32'h1234_5678},
      '{3'b111, 1'b0, 32'h0000_0001, 32'h0000_0000},
      '{3'b100, 1'b1, 32'hFFFF_FFFF, 32'h0000_0005},
      '{3'b101, 1'b1, 32'hFFFF_FFFF, 32'h0000_0005},
      '{3'b110, 1'b1, 32'hFFFF_FFFF, 32'h0000_0005},
      '{3'b111, 1'b1, 32'hFFFF_FFFF, 32'h0000_0005},
      '{3'b010, 1'b1, 32'hFFFF_FFFF, 32'h0000_0005},
      '{3'b101, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000},
      '{3'b011, 1'b0, 32'h0000_1234, 32'h0000_1300},
      '{3'b010, 1'b0, 32'hFFFF_FF00, 32'hFFFF_FF01}
    };
    exp_t e;
    int   lat;
    bit   to;
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].op, tbl[i].mm, tbl[i].a, tbl[i].b);
      wait_out(lat, to);
      e = sb.pop_front();
      checks++; if (to) $display("FAIL cmp[%0d].timeout out_valid never rose, want after %0d", i, e.k); else passed++;
      checks++; if (lat != e.k) $display("FAIL cmp[%0d].latency got %0d want %0d", i, lat, e.k); else passed++;
      checks++; if (out_flag !== e.flag) $display("FAIL cmp[%0d].flag got %b want %b", i, out_flag, e.flag); else passed++;
      checks++; if (out_value !== e.value) $display("FAIL cmp[%0d].value got %h want %h", i, out_value, e.value); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          lat;
    bit          to;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      case ($urandom_range(0, 2))
        0:       b = a;
        1:       b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = $urandom;
      endcase
      checks++; if (in_ready !== 1'b1) $display("FAIL b2b[%0d].in_ready got %b want 1", i, in_ready); else passed++;
      send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), a, b);
      wait_out(lat, to);
      e = sb.pop_front();
      checks++; if (to || lat != e.k) $display("FAIL b2b[%0d].latency got %0d want %0d", i, lat, e.k); else passed++;
      checks++; if (out_flag !== e.flag) $display("FAIL b2b[%0d].flag got %b want %b", i, out_flag, e.flag); else passed++;
      checks++; if (out_value !== e.value) $display("FAIL b2b[%0d].value got %h want %h", i, out_value, e.value); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    bit   to;
    bit   seen;
    out_ready = 1'b0;
    send(3'b100, 1'b0, 32'h0000_0010, 32'h0000_0020);
    wait_out(lat, to);
    e = sb.pop_front();
    checks++; if (to || lat != e.k) $display("FAIL bp.latency got %0d want %0d", lat, e.k); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        op = 3'b000; minmax = 1'b0; in1 = 32'h5; in2 = 32'h6;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) $display("FAIL bp[%0d].out_valid got %b want 1", i, out_valid); else passed++;
      checks++; if (out_value !== e.value) $display("FAIL bp[%0d].value got %h want %h", i, out_value, e.value); else passed++;
      checks++; if (out_flag !== e.flag) $display("FAIL bp[%0d].flag got %b want %b", i, out_flag, e.flag); else passed++;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp[%0d].in_ready got %b want 0", i, in_ready); else passed++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL bp.release.in_ready got %b want 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp.release.out_valid got %b want 0", out_valid); else passed++;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen) $display("FAIL bp.ignored_request produced out_valid, want none"); else passed++;
  endtask

  task automatic test_reset_busy();
    exp_t e;
    int   lat;
    bit   to;
    bit   seen;
    send(3'b000, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    void'(sb.pop_front());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL rstbusy.in_ready got %b want 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rstbusy.out_valid got %b want 0", out_valid); else passed++;
    checks++; if (out_value !== 32'h0) $display("FAIL rstbusy.out_value got %h want 0", out_value); else passed++;
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen) $display("FAIL rstbusy.stale out_valid after reset, want none"); else passed++;
    send(3'b110, 1'b0, 32'h0000_0003, 32'hFFFF_FFFF);
    wait_out(lat, to);
    e = sb.pop_front();
    checks++; if (to || lat != e.k) $display("FAIL rstbusy.next.latency got %0d want %0d", lat, e.k); else passed++;
    checks++; if (out_flag !== e.flag) $display("FAIL rstbusy.next.flag got %b want %b", out_flag, e.flag); else passed++;
    checks++; if (out_value !== e.value) $display("FAIL rstbusy.next.value got %h want %h", out_value, e.value); else passed++;
    @(negedge clk);
  endtask

  task automatic test_full_scan();
    req_t tbl [4] = '{
      '{3'b110, 1'b0, 32'h0000_0000, 32'hFF00_0000},
      '{3'b100, 1'b0, 32'h8000_0000, 32'h0000_0000},
      '{3'b101, 1'b1, 32'hFFFF_FFFF, 32'h0000_0005},
      '{3'b001, 1'b0, 32'h0101_0101, 32'h0101_0101}
    };
    exp_t e;
    int   lat;
    bit   to;
    for (int i = 0; i < 4; i++) begin
      op = tbl[i].op; minmax = tbl[i].mm; in1 = tbl[i].a; in2 = tbl[i].b;
      in_valid_fs = 1'b1;
      sb.push_back(model(tbl[i].op, tbl[i].mm, tbl[i].a, tbl[i].b, 1'b0));
      @(posedge clk); #1;
      in_valid_fs = 1'b0;
      lat = 0;
      to  = 1'b1;
      for (int c = 0; c < TMO; c++) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        if (fs_out_valid) begin
          to = 1'b0;
          break;
        end
      end
      e = sb.pop_front();
      checks++; if (to || lat != e.k) $display("FAIL fs[%0d].latency got %0d want %0d", i, lat, e.k); else passed++;
      checks++; if (fs_out_flag !== e.flag) $display("FAIL fs[%0d].flag got %b want %b", i, fs_out_flag, e.flag); else passed++;
      checks++; if (fs_out_value !== e.value) $display("FAIL fs[%0d].value got %h want %h", i, fs_out_value, e.value); else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_valid_fs = 1'b0;
    op          = '0;
    minmax      = 1'b0;
    in1         = '0;
    in2         = '0;
    out_ready   = 1'b1;
    test_reset();
    test_compare();
    test_back_to_back();
    test_backpressure();
    test_reset_busy();
    test_full_scan();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/serial_comparer.md
# serial_comparer

Parametrised, multi-cycle successor to the single-cycle comparer in the rv integer datapath. Compares two XLEN-bit operands one CHUNK-bit slice per cycle, most significant slice first, with optional early exit. Produces a branch/set-less-than flag and, in min/max mode, the selected operand. Sits behind the decode stage on a valid/ready handshake so narrow-area cores can share one slice comparator.

## Interface
- XLEN, 32, operand width
- CHUNK, 8, bits compared per cycle; XLEN % CHUNK must be 0, elaboration $fatal otherwise
- EARLY_EXIT, 1, 1 = finish at first differing slice; 0 = always scan all slices

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- op  in  3  funct3 encoding (see Operation)
- minmax  in  1  1 = Zbb min/max interpretation of op
- in1  in  XLEN  operand a
- in2  in  XLEN  operand b
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  consumer accepts result
- out_flag  out  1  compare result
- out_value  out  XLEN  min/max result, or zero-extended out_flag when minmax=0

## Operation
- Compare ops, minmax=0: 000 eq, 001 ne, 100/010 lt (signed), 101 ge (signed), 110/011 ltu, 111 geu.
- Min/max ops, minmax=1: 100 min, 101 minu, 110 max, 111 maxu; out_flag = (in1 < in2) under the op's signedness; out_value = selected operand. Ops 000-011 with minmax=1 are illegal: out_flag=0, out_value=0, normal latency.
- Signed ops: flip bit XLEN-1 of both captured operands, then compare unsigned.
- Handshake accept (in_valid && in_ready) captures op, minmax, in1, in2; later input changes ignored.
- FSM: IDLE -> BUSY on accept. BUSY examines slice idx, starting NCHUNK-1 (NCHUNK = XLEN/CHUNK), decrementing. Decision = slices differ (EARLY_EXIT=1) or idx==0. On decision: register lt/eq, derive outputs, -> DONE. DONE -> IDLE when out_ready.
- lt = a_slice < b_slice at first differing slice; eq = no differing slice.
- in_ready = (state == IDLE), combinational from state.
- out_valid = (state == DONE); out_flag/out_value stable throughout DONE.

## Timing
- Accept at cycle T; BUSY from T+1. out_valid asserted at T+1+k, where k = slices examined (1..NCHUNK). EARLY_EXIT=0: always T+1+NCHUNK.
- XLEN=32, CHUNK=8: top slice differs -> T+2; equal operands -> T+5. CHUNK=XLEN -> always T+2.
- out_ready high in first DONE cycle: IDLE next cycle, in_ready high; next accept no earlier than then. Minimum request spacing = latency + 1.
- out_ready low: stay in DONE indefinitely, outputs unchanged.
- in_valid in BUSY/DONE: ignored, not captured.
- Reset: state IDLE, out_valid 0, out_flag 0, out_value 0, in_ready 1 the cycle after reset. Reset mid-BUSY or in DONE aborts; no out_valid for the aborted request.

## Structure
- Package cmp_pkg: funct3 localparams for all compare and min/max ops; state enum typedef (IDLE, BUSY, DONE).
- Sub-module cmp_slice: combinational CHUNK-bit unsigned compare, outputs lt and eq; one instance, driven by muxed slice idx.
- Slice counter width $clog2(NCHUNK), minimum 1.

## Test plan
- op=100, minmax=0, in1=32'h80000000, in2=0 -> out_flag=1, out_value=1, out_valid at T+2 (EARLY_EXIT=1).
- op=000, in1=in2=32'h12345678 -> out_flag=1, out_valid at T+5; same with op=001 -> out_flag=0.
- op=111 (geu), in1=1, in2=0 -> out_flag=1 at T+5 (only slice 0 differs); EARLY_EXIT=0 build, op=110, in1=0, in2=32'hFF000000 -> out_flag=1 at T+5.
- minmax=1: op=100 in1=32'hFFFFFFFF, in2=5 -> out_value=32'hFFFFFFFF; op=101 -> 5; op=110 -> 5; op=111 -> 32'hFFFFFFFF; op=010 -> flag 0, value 0.
- Backpressure: out_ready=0 for 4 cycles -> out_valid/out_value held, in_ready=0, in_valid pulse with new operands ignored; out_ready=1 -> in_ready=1 next cycle.
- Reset asserted in BUSY -> next cycle in_ready=1, out_valid=0; no stale result appears afterwards; new request completes correctly.
